// File: rtl/img_pkg.sv
// Shared types and default frame geometry for the image pipeline blocks.
package img_pkg;

    localparam int DEF_WORD_SIZE = 8;
    localparam int DEF_ROW_SIZE  = 540;
    localparam int DEF_NUM_ROWS  = 540;

    typedef logic [DEF_WORD_SIZE-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        pixel_t pixel;
        logic   sof;
        logic   eol;
        logic   eof;
    } beat_t;

    // Counter width that never collapses to zero bits for a dimension of 1.
    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pix_skid_buffer.sv
// Two-entry FIFO of stream beats; entry 0 is always the head presented downstream.
module pix_skid_buffer
    import img_pkg::*;
#(
    parameter type T = beat_t
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  T           din,
    input  logic       pop,
    output T           head,
    output logic [1:0] count
);

    T           entry0_r;
    T           entry1_r;
    logic [1:0] count_r;

    // Storage shift/fill; a vacated tail slot is zeroed so stale beats never reach the head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry0_r <= '0;
            entry1_r <= '0;
            count_r  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        entry0_r <= din;
                    end else begin
                        entry1_r <= din;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    entry0_r <= entry1_r;
                    entry1_r <= '0;
                    count_r  <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        entry0_r <= din;
                    end else begin
                        entry0_r <= entry1_r;
                        entry1_r <= din;
                    end
                end
                default: begin
                    entry0_r <= entry0_r;
                    entry1_r <= entry1_r;
                    count_r  <= count_r;
                end
            endcase
        end
    end

    assign head  = entry0_r;
    assign count = count_r;

endmodule

// File: rtl/pixel_streamer.sv
// Reads one raster frame from a 1-cycle-latency memory and emits it as a
// valid/ready pixel stream with sof/eol/eof markers.
module pixel_streamer
    import img_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int ROW_SIZE  = DEF_ROW_SIZE,
    parameter int NUM_ROWS  = DEF_NUM_ROWS,
    parameter int ADDR_W    = $clog2(ROW_SIZE * NUM_ROWS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 mem_rd_en,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic [WORD_SIZE-1:0] pix_data,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic                 pix_sof,
    output logic                 pix_eol,
    output logic                 pix_eof,
    output logic                 busy,
    output logic                 done
);

    localparam int COL_W = min1_clog2(ROW_SIZE);
    localparam int ROW_W = min1_clog2(NUM_ROWS);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_SIZE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);

    typedef struct packed {
        logic [WORD_SIZE-1:0] pixel;
        logic                 sof;
        logic                 eol;
        logic                 eof;
    } stream_beat_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [ADDR_W-1:0] addr_r;
    logic [COL_W-1:0]  col_r;
    logic [ROW_W-1:0]  row_r;
    logic          inflight_r;
    logic [2:0]    meta_r;
    logic          busy_r;
    logic          done_r;
    logic          rd_en_s;
    logic          pop_s;
    logic          room_s;
    logic          sof_s;
    logic          eol_s;
    logic          eof_s;
    stream_beat_t  skid_in_s;
    stream_beat_t  skid_head_s;
    logic [1:0]    skid_count_s;

    assign sof_s = (col_r == '0) && (row_r == '0);
    assign eol_s = (col_r == COL_LAST);
    assign eof_s = eol_s && (row_r == ROW_LAST);
    assign pop_s = (skid_count_s != 2'd0) && pix_ready;

    // A same-cycle pop frees a slot, so the read stream never bubbles under full throughput.
    assign room_s = ({1'b0, skid_count_s} + {2'b00, inflight_r}) < (3'd2 + {2'b00, pop_s});

    // Next-state and read-issue decode.
    always_comb begin
        state_next_s = state_r;
        rd_en_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                rd_en_s = room_s;
                if (room_s && eof_s) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = RUN;
                end
            end
            DRAIN: begin
                if (pop_s && skid_head_s.eof) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Read address and raster position; the address parks on the last pixel after the final read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_r <= '0;
            col_r  <= '0;
            row_r  <= '0;
        end else if ((state_r == IDLE) && start) begin
            addr_r <= '0;
            col_r  <= '0;
            row_r  <= '0;
        end else if (rd_en_s) begin
            if (!eof_s) begin
                addr_r <= addr_r + ADDR_W'(1);
            end
            if (eol_s) begin
                col_r <= '0;
                row_r <= eof_s ? '0 : row_r + ROW_W'(1);
            end else begin
                col_r <= col_r + COL_W'(1);
            end
        end
    end

    // Markers travel with the outstanding read so they pair with the returning data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_r <= 1'b0;
            meta_r     <= 3'b000;
        end else begin
            inflight_r <= rd_en_s;
            if (rd_en_s) begin
                meta_r <= {sof_s, eol_s, eof_s};
            end
        end
    end

    // Registered status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s == RUN) || (state_next_s == DRAIN);
            done_r <= (state_next_s == DONE);
        end
    end

    // Beat assembly for the skid buffer input.
    always_comb begin
        skid_in_s       = '0;
        skid_in_s.pixel = mem_rdata;
        skid_in_s.sof   = meta_r[2];
        skid_in_s.eol   = meta_r[1];
        skid_in_s.eof   = meta_r[0];
    end

    pix_skid_buffer #(
        .T(stream_beat_t)
    ) u_skid (
        .clk  (clk),
        .rst  (rst),
        .push (inflight_r),
        .din  (skid_in_s),
        .pop  (pop_s),
        .head (skid_head_s),
        .count(skid_count_s)
    );

    assign mem_rd_en = rd_en_s;
    assign mem_addr  = addr_r;
    assign pix_data  = skid_head_s.pixel;
    assign pix_valid = (skid_count_s != 2'd0);
    assign pix_sof   = skid_head_s.sof;
    assign pix_eol   = skid_head_s.eol;
    assign pix_eof   = skid_head_s.eof;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_pixel_streamer.sv
// Randomized and directed bench for pixel_streamer against a frame-level behavioural model.
module tb_pixel_streamer;

    localparam int RS   = 4;
    localparam int NR   = 3;
    localparam int NPIX = RS * NR;
    localparam int W    = 8;
    localparam int AW   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          pix_ready = 1'b1;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_rdata = '0;
    logic [W-1:0]  pix_data;
    logic          pix_valid, pix_sof, pix_eol, pix_eof, busy, done;

    pixel_streamer #(.WORD_SIZE(W), .ROW_SIZE(RS), .NUM_ROWS(NR), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mem [NPIX];
    initial for (int i = 0; i < NPIX; i++) mem[i] = W'(i + 16);

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= (int'(mem_addr) < NPIX) ? mem[mem_addr] : 8'h00;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Frame-level model: a frame is NPIX beats, beat k = 16+k, markers from k.
    int   cyc = 0, beat_m = 0, issued_m = 0, frames_m = 0;
    int   start_cyc = 0, frame_len = 0, eof_cyc = 0;
    bit   in_frame_m = 0, done_m = 0, hold_v = 0;
    logic [W+2:0] hold_val = '0;
    logic [W-1:0] obs_q[$];
    logic xfer, exp_rd;

    assign xfer   = pix_valid & pix_ready;
    assign exp_rd = in_frame_m && (issued_m < NPIX) &&
                    ((issued_m - beat_m - (xfer ? 1 : 0)) < 2);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            in_frame_m <= 0; done_m <= 0; beat_m <= 0; issued_m <= 0; hold_v <= 0;
        end else begin
            chk("rd_en", 32'(mem_rd_en), 32'(exp_rd));
            if (mem_rd_en) chk("mem_addr", 32'(mem_addr), 32'(issued_m));
            done_m <= xfer && (beat_m == NPIX - 1);
            if (!in_frame_m && !done_m && start) begin
                in_frame_m <= 1; beat_m <= 0; issued_m <= 0; start_cyc <= cyc;
            end
            if (mem_rd_en) issued_m <= issued_m + 1;
            if (xfer) begin
                obs_q.push_back(pix_data);
                beat_m <= beat_m + 1;
                if (beat_m == NPIX - 1) begin
                    in_frame_m <= 0;
                    frames_m   <= frames_m + 1;
                    frame_len  <= cyc - start_cyc;
                    eof_cyc    <= cyc;
                end
            end
            hold_v   <= pix_valid && !pix_ready;
            hold_val <= {pix_data, pix_sof, pix_eol, pix_eof};
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("busy", 32'(busy), 32'(in_frame_m));
            chk("done", 32'(done), 32'(done_m));
            if (pix_valid) begin
                chk("valid_in_frame", 32'(in_frame_m), 32'd1);
                chk("pix_data", 32'(pix_data), 32'(16 + beat_m));
                chk("pix_sof", 32'(pix_sof), 32'(beat_m == 0));
                chk("pix_eol", 32'(pix_eol), 32'((beat_m % RS) == RS - 1));
                chk("pix_eof", 32'(pix_eof), 32'(beat_m == NPIX - 1));
            end
            chk("occupancy_le2", 32'((issued_m - beat_m) <= 2), 32'd1);
            if (hold_v) chk("hold_stable", 32'({pix_valid, pix_data, pix_sof, pix_eol, pix_eof}),
                            32'({1'b1, hold_val}));
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_data"}, 32'(pix_data), 32'd0);
        chk({tag, "_valid"}, 32'(pix_valid), 32'd0);
        chk({tag, "_markers"}, 32'({pix_sof, pix_eol, pix_eof}), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int i = 0;
        while (frames_m < target && i < budget) begin @(negedge clk); i++; end
        chk("frame_timeout", 32'(frames_m >= target), 32'd1);
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (!done && i < budget) begin @(negedge clk); i++; end
        chk("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    initial begin
        int base, r, nv, nd;
        logic [5:0] pat;
        pat = 6'b101001;  // applied LSB first: 1,0,0,1,0,1

        repeat (3) @(posedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk); rst = 1'b1;

        // Free-flowing frame with literal latency pins.
        obs_q.delete();
        pulse_start();
        @(posedge clk); #1 chk("valid_after_E1", 32'(pix_valid), 32'd0);
        @(posedge clk); #1 chk("valid_after_E2", 32'(pix_valid), 32'd1);
        chk("first_data", 32'(pix_data), 32'd16);
        chk("first_sof", 32'(pix_sof), 32'd1);
        wait_frames(1, 100);
        chk("frame_len", 32'(frame_len), 32'd14);
        chk("beats", 32'(obs_q.size()), 32'd12);
        if (obs_q.size() == 12) begin
            chk("beat5", 32'(obs_q[5]), 32'd21);
            chk("beat11", 32'(obs_q[11]), 32'd27);
        end
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);

        // Backpressure pattern 1,0,0,1,0,1 repeating.
        obs_q.delete();
        base = frames_m;
        for (int k = 0; k < 300 && frames_m == base; k++) begin
            @(negedge clk);
            pix_ready = pat[k % 6];
            start = (k == 0);
        end
        start = 1'b0; pix_ready = 1'b1;
        wait_frames(base + 1, 10);
        chk("bp_beats", 32'(obs_q.size()), 32'd12);
        for (int i = 0; i < 12 && i < obs_q.size(); i++) chk("bp_seq", 32'(obs_q[i]), 32'(16 + i));

        // Stall from start for 10 cycles.
        repeat (2) @(negedge clk);
        base = frames_m;
        @(negedge clk); pix_ready = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        chk("stall_reads", 32'(issued_m), 32'd2);
        r = cyc;
        pix_ready = 1'b1;
        wait_frames(base + 1, 100);
        chk("stall_no_gap", 32'(eof_cyc - r), 32'd11);

        // Start re-pulsed in RUN and in DONE is ignored.
        obs_q.delete();
        base = frames_m;
        pulse_start();
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done(100);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (20) @(negedge clk);
        chk("ignored_frames", 32'(frames_m - base), 32'd1);
        chk("ignored_beats", 32'(obs_q.size()), 32'd12);
        pulse_start();
        wait_frames(base + 2, 100);
        chk("second_beats", 32'(obs_q.size()), 32'd24);
        if (obs_q.size() == 24) chk("second_first", 32'(obs_q[12]), 32'd16);

        // Asynchronous reset mid-row.
        repeat (2) @(negedge clk);
        pulse_start();
        for (int i = 0; i < 100 && beat_m < 6; i++) @(negedge clk);
        chk("reached_beat6", 32'(beat_m >= 6), 32'd1);
        #2 rst = 1'b0;
        #1 chk_all_zero("midreset");
        @(negedge clk); rst = 1'b1;
        nv = 0; nd = 0;
        repeat (20) begin @(negedge clk); #1; if (pix_valid) nv++; if (done) nd++; end
        chk("post_reset_valid", 32'(nv), 32'd0);
        chk("post_reset_done", 32'(nd), 32'd0);
        obs_q.delete();
        base = frames_m;
        pulse_start();
        wait_frames(base + 1, 100);
        if (obs_q.size() > 0) chk("restart_first", 32'(obs_q[0]), 32'd16);

        // Back-to-back: start in the cycle after done.
        wait_done(20);
        base = frames_m;
        pulse_start();
        wait_frames(base + 1, 100);
        chk("b2b_len", 32'(frame_len), 32'd14);

        // Random ready and random start pulses.
        base = frames_m;
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            pix_ready = ($urandom_range(0, 3) != 0);
            start = ($urandom_range(0, 9) == 0);
        end
        start = 1'b0; pix_ready = 1'b1;
        for (int i = 0; i < 100 && (in_frame_m || done_m); i++) @(negedge clk);
        chk("random_frames", 32'(frames_m > base), 32'd1);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pixel_streamer.md
Name: pixel_streamer

Overview:
- Raster-order pixel source that feeds the 3x3 convolution front end.
- On `start`, reads one frame of NUM_ROWS x ROW_SIZE pixels from a synchronous-read frame memory with 1-cycle read latency.
- Emits the pixels as a valid/ready stream with start-of-frame and end-of-line/end-of-frame markers.
- Absorbs downstream backpressure without losing or repeating pixels, using a 2-entry skid buffer.

Parameters:
- WORD_SIZE, 8, pixel width in bits
- ROW_SIZE, 540, pixels per row
- NUM_ROWS, 540, rows per frame
- ADDR_W, $clog2(ROW_SIZE*NUM_ROWS), frame memory address width (derived)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- start  in  1  begin streaming one frame; sampled only in IDLE
- mem_rd_en  out  1  read strobe to frame memory
- mem_addr  out  ADDR_W  read address, row*ROW_SIZE+col
- mem_rdata  in  WORD_SIZE  read data, valid the cycle after mem_rd_en
- pix_data  out  WORD_SIZE  output pixel
- pix_valid  out  1  pix_data is valid
- pix_ready  in  1  downstream accepts; a transfer occurs when pix_valid & pix_ready
- pix_sof  out  1  qualifies pix_data as pixel (0,0)
- pix_eol  out  1  qualifies pix_data as last pixel of a row
- pix_eof  out  1  qualifies pix_data as last pixel of the frame
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the eof transfer

Behaviour:
- Reset (rst=0, async):
  - FSM returns to IDLE; read counter, skid buffer and in-flight flag are cleared.
  - All outputs are 0: mem_rd_en, mem_addr, pix_data, pix_valid, pix_sof, pix_eol, pix_eof, busy, done.
  - Reset asserted mid-frame aborts the frame. No pixels or done pulse appear after release. The next frame requires a new start.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start=1; read address counter is cleared to 0; busy=1 from the next cycle.
  - RUN -> DRAIN after the read of address ROW_SIZE*NUM_ROWS-1 is issued.
  - DRAIN -> DONE on the transfer carrying pix_eof.
  - DONE -> IDLE unconditionally after one cycle. done=1 and busy=0 during DONE.
- start is ignored outside IDLE.
- Read issue rule: mem_rd_en=1 in a cycle only if the FSM is in RUN and (skid occupancy + in-flight read) < 2, counting a pop in the same cycle as freeing a slot.
  - The address counter increments only on an issued read.
  - mem_addr holds its last value when mem_rd_en=0.
- Skid buffer:
  - mem_rdata is pushed the cycle after an issued read.
  - Head entry drives pix_data; pix_valid = not empty.
  - Pop on pix_valid & pix_ready. Simultaneous push and pop keeps occupancy unchanged.
  - The issue rule guarantees overflow is impossible. The bench asserts this.
- Markers:
  - Column/row counters (col 0..ROW_SIZE-1, row 0..NUM_ROWS-1) track read issue. Marker bits are stored in the skid buffer alongside the data.
  - pix_sof marks col=0,row=0. pix_eol marks col=ROW_SIZE-1. pix_eof marks col=ROW_SIZE-1,row=NUM_ROWS-1.
  - The last pixel of the frame has eol=1 and eof=1.
  - Column wraps to 0 and row increments on the eol read.
- Output stability: while pix_valid=1 and pix_ready=0, pix_data and all markers hold stable.
- Latency with pix_ready held at 1:
  - start is sampled at edge E0.
  - First read (addr 0) is issued in the cycle after E0.
  - pix_valid=1 with pix_sof after edge E2.
  - Thereafter one pixel per cycle, no bubbles. A frame takes ROW_SIZE*NUM_ROWS+2 cycles from start to the eof transfer.
- Width rules:
  - Address arithmetic is unsigned, ADDR_W bits.
  - Counters are sized $clog2(ROW_SIZE) and $clog2(NUM_ROWS) bits, each with a minimum of 1.

Decomposition:
- Shared package `img_pkg`:
  - typedef for pixel word (WORD_SIZE)
  - state enum {IDLE, RUN, DRAIN, DONE}
  - struct {pixel, sof, eol, eof} for stream beats
  - default frame dimension constants (ROW_SIZE, NUM_ROWS)
- One sub-module, `pix_skid_buffer`: 2-entry FIFO of stream-beat structs with push/pop and occupancy count. It is reused later on the convolution output side.

Test Plan (ROW_SIZE=4, NUM_ROWS=3, memory preloaded with mem[i]=i+16):
- Free-flowing frame: pix_ready=1, start pulse at E0.
  - pix_valid rises after E2; 12 consecutive beats carry data 16..27.
  - sof on beat 0; eol on beats 3, 7, 11; eof on beat 11.
  - done pulses 1 cycle after beat 11; busy=0 thereafter.
- Backpressure: pix_ready toggled 1,0,0,1,0,1...
  - Output sequence is still 16..27 exactly, with no duplicates or drops.
  - pix_data is stable across every ready=0 cycle.
  - Skid occupancy never exceeds 2, and mem_rd_en=0 whenever occupancy + in-flight = 2.
- pix_ready=0 from start for 10 cycles, then 1.
  - Exactly 2 reads are issued (addr 0, 1) during the stall.
  - Beats 16, 17, 18... follow without a gap once ready rises.
- start re-pulsed during RUN and again in DONE.
  - Both are ignored; only one frame of 12 beats is produced.
  - A start in IDLE afterward produces a second identical frame.
- rst driven to 0 asynchronously mid-row (after beat 5, between edges).
  - All outputs are 0 immediately.
  - After release: no beats and no done pulse until a new start; the next frame begins at data 16 with sof.
- Back-to-back frames: start asserted in the cycle after done.
  - The second frame's sof beat carries 16.
  - Total cycles for the second frame from start to eof transfer = 14.
